// File: rtl/tns_bus_scheduler.sv
// Round-robin burst scheduler that time-multiplexes NREQ sources onto one TNS encoder/bus.
// Drives the encoder word from a register and emits an owner tag aligned with the encoder's codeout.
module tns_bus_scheduler #(
    parameter int NREQ      = 4,
    parameter int DATA_W    = 18,
    parameter int MAX_BURST = 8,
    parameter int GAP_CYC   = 1
) (
    input  logic                     clock,
    input  logic                     rst,
    input  logic [NREQ-1:0]          req_valid,
    input  logic [NREQ*DATA_W-1:0]   req_data,
    output logic [NREQ-1:0]          req_ready,
    output logic [DATA_W-1:0]        enc_data,
    output logic                     tag_valid,
    output logic [$clog2(NREQ)-1:0]  tag_id,
    output logic                     busy
);
    localparam int ID_W = $clog2(NREQ);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BURST = 2'd1,
        ST_GAP   = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [ID_W-1:0]     owner_q, owner_d;
    logic [ID_W-1:0]     rr_ptr_q, rr_ptr_d;
    logic [7:0]          beat_cnt_q, beat_cnt_d;
    logic [3:0]          gap_cnt_q, gap_cnt_d;
    logic [DATA_W-1:0]   enc_data_q, enc_data_d;
    logic                tag1_v_q, tag1_v_d;
    logic [ID_W-1:0]     tag1_id_q, tag1_id_d;
    logic                tag_valid_q, tag_valid_d;
    logic [ID_W-1:0]     tag_id_q, tag_id_d;
    logic [NREQ-1:0]     ready_q, ready_d;
    logic                busy_q, busy_d;

    logic [DATA_W-1:0]   data_arr_s [NREQ];
    logic                beat_s;
    logic                do_arb_s;
    logic [ID_W-1:0]     arb_base_s;
    logic [ID_W-1:0]     next_ptr_s;
    logic [ID_W:0]       pick_s;

    for (genvar g = 0; g < NREQ; g++) begin : g_unpack
        assign data_arr_s[g] = req_data[g*DATA_W +: DATA_W];
    end

    // Returns {found, index} of the first valid requester at or after base, wrapping.
    function automatic logic [ID_W:0] rr_pick(input logic [NREQ-1:0] valid,
                                              input logic [ID_W-1:0] base);
        logic [ID_W:0] res;
        int            idx;
        res = {(ID_W+1){1'b0}};
        for (int i = NREQ - 1; i >= 0; i--) begin
            idx = (int'(base) + i) % NREQ;
            if (valid[ID_W'(idx)]) begin
                res = {1'b1, ID_W'(idx)};
            end
        end
        return res;
    endfunction

    // Next-state, datapath and output decode for the arbiter and tag pipeline.
    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        rr_ptr_d    = rr_ptr_q;
        beat_cnt_d  = beat_cnt_q;
        gap_cnt_d   = gap_cnt_q;
        enc_data_d  = enc_data_q;
        do_arb_s    = 1'b0;
        arb_base_s  = rr_ptr_q;
        pick_s      = {(ID_W+1){1'b0}};
        beat_s      = (state_q == ST_BURST) && req_valid[owner_q];
        next_ptr_s  = (owner_q == ID_W'(NREQ - 1)) ? {ID_W{1'b0}} : owner_q + ID_W'(1);

        case (state_q)
            ST_IDLE: begin
                do_arb_s = 1'b1;
            end
            ST_BURST: begin
                if (beat_s) begin
                    enc_data_d = data_arr_s[owner_q];
                    beat_cnt_d = beat_cnt_q + 8'd1;
                end else begin
                    beat_cnt_d = beat_cnt_q;
                end
                // A missing beat and reaching the burst limit end the grant through the same path.
                if (!beat_s || (beat_cnt_q + 8'd1 == 8'(MAX_BURST))) begin
                    rr_ptr_d = next_ptr_s;
                    if (GAP_CYC > 0) begin
                        state_d   = ST_GAP;
                        gap_cnt_d = 4'd0;
                    end else begin
                        do_arb_s   = 1'b1;
                        arb_base_s = next_ptr_s;
                    end
                end else begin
                    state_d = ST_BURST;
                end
            end
            ST_GAP: begin
                gap_cnt_d = gap_cnt_q + 4'd1;
                if (gap_cnt_q + 4'd1 == 4'(GAP_CYC)) begin
                    do_arb_s = 1'b1;
                end else begin
                    do_arb_s = 1'b0;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (do_arb_s) begin
            pick_s = rr_pick(req_valid, arb_base_s);
            if (pick_s[ID_W]) begin
                state_d    = ST_BURST;
                owner_d    = pick_s[ID_W-1:0];
                beat_cnt_d = 8'd0;
            end else begin
                state_d = ST_IDLE;
            end
        end else begin
            pick_s = {(ID_W+1){1'b0}};
        end

        ready_d     = (state_d == ST_BURST) ? ({{(NREQ-1){1'b0}}, 1'b1} << owner_d) : {NREQ{1'b0}};
        busy_d      = (state_d != ST_IDLE);
        tag1_v_d    = beat_s;
        tag1_id_d   = beat_s ? owner_q : tag1_id_q;
        tag_valid_d = tag1_v_q;
        tag_id_d    = tag1_id_q;
    end

    // State and output registers; reset aborts any burst and drops in-flight tags.
    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            owner_q     <= {ID_W{1'b0}};
            rr_ptr_q    <= {ID_W{1'b0}};
            beat_cnt_q  <= 8'd0;
            gap_cnt_q   <= 4'd0;
            enc_data_q  <= {DATA_W{1'b0}};
            tag1_v_q    <= 1'b0;
            tag1_id_q   <= {ID_W{1'b0}};
            tag_valid_q <= 1'b0;
            tag_id_q    <= {ID_W{1'b0}};
            ready_q     <= {NREQ{1'b0}};
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            rr_ptr_q    <= rr_ptr_d;
            beat_cnt_q  <= beat_cnt_d;
            gap_cnt_q   <= gap_cnt_d;
            enc_data_q  <= enc_data_d;
            tag1_v_q    <= tag1_v_d;
            tag1_id_q   <= tag1_id_d;
            tag_valid_q <= tag_valid_d;
            tag_id_q    <= tag_id_d;
            ready_q     <= ready_d;
            busy_q      <= busy_d;
        end
    end

    assign req_ready = ready_q;
    assign enc_data  = enc_data_q;
    assign tag_valid = tag_valid_q;
    assign tag_id    = tag_id_q;
    assign busy      = busy_q;

endmodule
